// File: rtl/store_write_arbiter.sv
// -----------------------------------------------------------------------------
// store_write_arbiter
//   Shares the data-memory write port between two store requesters. A
//   round-robin arbiter picks one requester while idle, accepts it with a
//   valid/ready handshake, and then plays the store out as memory writes, one
//   element per cycle: one beat for a scalar store, LANES beats for a vector
//   store. Ready is only offered in IDLE, so there is one idle bubble between
//   stores.
//
// Ports
//   clk            system clock, all state on the rising edge
//   rst            synchronous, active-high reset
//   reqN_valid     requester N (N=0,1) has a store pending
//   reqN_ready     requester N store is accepted this cycle if valid
//   reqN_op_type   0 = scalar store, 1 = vector store
//   reqN_base      base address of the store
//   reqN_sdata     scalar store data
//   reqN_vdata     vector store data, element i = bits [i*DATA_W +: DATA_W]
//   mem_we         memory write enable
//   mem_addr       memory write address (holds while mem_we=0)
//   mem_wdata      memory write data (holds while mem_we=0)
//   busy           high while a store is being written
//   done           one-cycle pulse on the final beat of a store
//   done_id        requester id of the completing store (valid with done)
// -----------------------------------------------------------------------------
module store_write_arbiter #(
  parameter int LANES  = 20,
  parameter int DATA_W = 10,
  parameter int ADDR_W = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic                      req0_op_type,
  input  logic [ADDR_W-1:0]         req0_base,
  input  logic [DATA_W-1:0]         req0_sdata,
  input  logic [LANES*DATA_W-1:0]   req0_vdata,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic                      req1_op_type,
  input  logic [ADDR_W-1:0]         req1_base,
  input  logic [DATA_W-1:0]         req1_sdata,
  input  logic [LANES*DATA_W-1:0]   req1_vdata,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      done_id
);

  localparam int BEAT_W = $clog2(LANES);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  logic [0:0]                    state;
  logic                          last_grant;
  logic                          sel;
  logic [BEAT_W-1:0]             beat;
  logic [BEAT_W-1:0]             next_beat;
  // Only elements 1..LANES-1 need to be kept: element 0 (or the scalar data)
  // goes straight onto mem_wdata at the accept edge.
  logic [(LANES-1)*DATA_W-1:0]   rest_q;

  logic                          accept;
  logic                          acc_op;
  logic [ADDR_W-1:0]             acc_base;
  logic [DATA_W-1:0]             acc_sdata;
  logic [LANES*DATA_W-1:0]       acc_vdata;

  // Round-robin select. With exactly one requester valid it wins outright;
  // otherwise (both or none) the side that was not granted last is chosen.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    sel = ~last_grant;
    if (req0_valid && !req1_valid) begin
      sel = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      sel = 1'b1;
    end
  end

  assign req0_ready = (state == ST_IDLE) && !sel && !rst;
  assign req1_ready = (state == ST_IDLE) &&  sel && !rst;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign acc_op    = sel ? req1_op_type : req0_op_type;
  assign acc_base  = sel ? req1_base    : req0_base;
  assign acc_sdata = sel ? req1_sdata   : req0_sdata;
  assign acc_vdata = sel ? req1_vdata   : req0_vdata;

  assign next_beat = beat + BEAT_W'(1);
  assign busy      = (state == ST_WRITE);

  // The done register doubles as the "this is the last beat" flag: it is set
  // when the last beat is loaded, so WRITE simply finishes when done is high.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      done_id    <= 1'b0;
      beat       <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            last_grant <= sel;
            done_id    <= sel;
            mem_we     <= 1'b1;
            mem_addr   <= acc_base;
            mem_wdata  <= acc_op ? acc_vdata[DATA_W-1:0] : acc_sdata;
            beat       <= '0;
            done       <= ~acc_op;
            state      <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (done) begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            beat      <= next_beat;
            // Address wraps modulo 2^ADDR_W by plain overflow.
            mem_addr  <= mem_addr + ADDR_W'(1);
            // Element beat+1 of the vector sits at index beat of rest_q.
            mem_wdata <= rest_q[int'(beat)*DATA_W +: DATA_W];
            done      <= (next_beat == BEAT_W'(LANES - 1));
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: pure datapath storage carries no reset; it is only read after an
  // accept has loaded it.
  always_ff @(posedge clk) begin
    if (accept) begin
      rest_q <= acc_vdata[LANES*DATA_W-1:DATA_W];
    end
  end

endmodule

// File: tb/tb_store_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_store_write_arbiter
//   Transaction-level reference model plus scoreboard for store_write_arbiter.
//   The driver computes which requester should be granted from the round-robin
//   rules and the model's own occupancy count, and on every handshake expands
//   the store into its expected beats (address, data, last flag, owner) on a
//   queue. An independent monitor pops that queue whenever mem_we is seen.
// -----------------------------------------------------------------------------
module tb_store_write_arbiter;

  localparam int LANES  = 20;
  localparam int DATA_W = 10;
  localparam int ADDR_W = 6;

  logic                    clk;
  logic                    rst;
  logic                    req0_valid, req1_valid;
  logic                    req0_ready, req1_ready;
  logic                    req0_op_type, req1_op_type;
  logic [ADDR_W-1:0]       req0_base, req1_base;
  logic [DATA_W-1:0]       req0_sdata, req1_sdata;
  logic [LANES*DATA_W-1:0] req0_vdata, req1_vdata;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    busy, done, done_id;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                last;
    bit                id;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests   = 0;
  int    n_fail    = 0;
  int    model_last = 1;
  int    busy_left = 0;
  bit    mon_en    = 0;

  store_write_arbiter #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op_type(req0_op_type),
    .req0_base(req0_base), .req0_sdata(req0_sdata), .req0_vdata(req0_vdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op_type(req1_op_type),
    .req1_base(req1_base), .req1_sdata(req1_sdata), .req1_vdata(req1_vdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .done_id(done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model step, run shortly after each falling edge once the
  // inputs for this cycle are applied.
  task automatic evaluate();
    int                      exp_sel;
    bit                      idle;
    bit                      op;
    logic [ADDR_W-1:0]       base;
    logic [DATA_W-1:0]       sd;
    logic [LANES*DATA_W-1:0] vd;
    int                      n;
    beat_t                   b;
    #1;
    if (rst) begin
      check("ready0_in_rst", req0_ready, 0);
      check("ready1_in_rst", req1_ready, 0);
      // Whatever store was in flight is abandoned at this edge.
      exp_q.delete();
      busy_left  = 0;
      model_last = 1;
      return;
    end
    idle = (busy_left == 0);
    if (!idle) busy_left--;
    check("busy", busy, !idle);
    if (req0_valid && !req1_valid)      exp_sel = 0;
    else if (req1_valid && !req0_valid) exp_sel = 1;
    else                                exp_sel = 1 - model_last;
    check("ready0", req0_ready, idle && exp_sel == 0);
    check("ready1", req1_ready, idle && exp_sel == 1);
    if (idle && ((exp_sel == 0 && req0_valid) || (exp_sel == 1 && req1_valid))) begin
      op   = (exp_sel == 1) ? req1_op_type : req0_op_type;
      base = (exp_sel == 1) ? req1_base    : req0_base;
      sd   = (exp_sel == 1) ? req1_sdata   : req0_sdata;
      vd   = (exp_sel == 1) ? req1_vdata   : req0_vdata;
      n    = op ? LANES : 1;
      for (int i = 0; i < n; i++) begin
        b.addr = ADDR_W'((int'(base) + i) % (1 << ADDR_W));
        b.data = op ? vd[i*DATA_W +: DATA_W] : sd;
        b.last = (i == n - 1);
        b.id   = (exp_sel == 1);
        exp_q.push_back(b);
      end
      busy_left  = n;
      model_last = exp_sel;
    end
  endtask

  task automatic tick();
    evaluate();
    @(negedge clk);
  endtask

  task automatic fill_vec(output logic [LANES*DATA_W-1:0] v, input int start, input bit rnd);
    for (int i = 0; i < LANES; i++) begin
      v[i*DATA_W +: DATA_W] = rnd ? DATA_W'($urandom) : DATA_W'(start + i);
    end
  endtask

  // Monitor: every memory write must match the head of the expected queue.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mem_we === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            b = exp_q.pop_front();
            check("mem_addr", mem_addr, b.addr);
            check("mem_wdata", mem_wdata, b.data);
            check("done", done, b.last);
            if (b.last) check("done_id", done_id, b.id);
          end
        end else begin
          check("mem_we_known", mem_we, 0);
          check("done_when_idle", done, 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_op_type = 0; req1_op_type = 0;
    req0_base = '0; req1_base = '0; req0_sdata = '0; req1_sdata = '0;
    req0_vdata = '0; req1_vdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset state, with both requesters asking: ready must stay low in reset.
    req0_valid = 1; req1_valid = 1;
    #1;
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    check("rst_busy", busy, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    @(negedge clk);
    rst = 0; req0_valid = 0; req1_valid = 0;
    mon_en = 1;

    // Scalar store from requester 0.
    req0_valid = 1; req0_op_type = 0; req0_base = 34; req0_sdata = 160;
    tick();
    req0_valid = 0;
    repeat (3) tick();

    // Vector store from requester 1, no wrap.
    req1_valid = 1; req1_op_type = 1; req1_base = 34; fill_vec(req1_vdata, 50, 0);
    tick();
    req1_valid = 0;
    repeat (22) tick();

    // Vector store from requester 0 wrapping past the top of memory, with the
    // requester inputs scrambled right after the accept edge.
    req0_valid = 1; req0_op_type = 1; req0_base = 60; fill_vec(req0_vdata, 50, 0);
    tick();
    req0_valid = 0; req0_base = 7; fill_vec(req0_vdata, 0, 1); req0_sdata = 10'h3FF;
    repeat (22) tick();

    // Both requesters continuously asking with scalar stores.
    req0_op_type = 0; req1_op_type = 0;
    for (int k = 0; k < 8; k++) begin
      req0_valid = 1; req1_valid = 1;
      req0_base = ADDR_W'($urandom); req1_base = ADDR_W'($urandom);
      req0_sdata = DATA_W'($urandom); req1_sdata = DATA_W'($urandom);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    repeat (2) tick();

    // Reset in the middle of a vector store (while beat 4 is on the port).
    req1_valid = 1; req1_op_type = 1; req1_base = 5; fill_vec(req1_vdata, 0, 1);
    tick();
    req1_valid = 0;
    repeat (4) tick();
    rst = 1;
    tick();
    rst = 0;
    req0_valid = 1; req1_valid = 1; req0_op_type = 0; req1_op_type = 0;
    req0_base = 12; req0_sdata = 99;
    tick();
    req0_valid = 0; req1_valid = 0;
    repeat (3) tick();

    // Randomized traffic, with occasional resets.
    for (int k = 0; k < 2500; k++) begin
      rst          = ($urandom_range(0, 299) == 0);
      req0_valid   = $urandom_range(0, 1) == 1;
      req1_valid   = $urandom_range(0, 1) == 1;
      req0_op_type = $urandom_range(0, 3) == 0;
      req1_op_type = $urandom_range(0, 3) == 0;
      req0_base    = ADDR_W'($urandom);
      req1_base    = ADDR_W'($urandom);
      req0_sdata   = DATA_W'($urandom);
      req1_sdata   = DATA_W'($urandom);
      fill_vec(req0_vdata, 0, 1);
      fill_vec(req1_vdata, 0, 1);
      tick();
    end

    // Drain whatever is still in flight, within a bounded number of cycles.
    rst = 0; req0_valid = 0; req1_valid = 0;
    for (int k = 0; k < 40 && (exp_q.size() != 0 || busy_left != 0); k++) tick();
    tick();
    check("drain_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
